// File: rtl/ahb_dbg_master.sv
// ahb_dbg_master
// Single-word AHB-Lite master shared by two debug requesters
// (0 = JTAG ADDR/WDATA/RDATA path, 1 = secondary debug/boot port).
// Requests are granted round-robin. One transfer is in flight at a time,
// with proper address/data phasing, HREADY wait states, HRESP error capture
// and a wait-state timeout.
//
// Ports
//   HCLK, HRESET     clock and synchronous active-high reset
//   REQ_VALID/READY  per-requester command handshake (READY is a one-hot pulse)
//   REQ_WRITE        per-requester direction, 1 = write
//   REQ_ADDR/WDATA   per-requester command fields, requester i in slice i
//   RSP_VALID        one-hot completion pulse to the requester that was granted
//   RSP_RDATA        read data, 0 for writes and for any error
//   RSP_ERR          bus error, timeout or misaligned address
//   BUSY             high whenever a command is being processed
//   HREADY/HRESP/HRDATA          AHB slave response inputs
//   HTRANS/HWRITE/HSIZE/HADDR/HWDATA  AHB master outputs
module ahb_dbg_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [1:0]              REQ_VALID,
  output logic [1:0]              REQ_READY,
  input  logic [1:0]              REQ_WRITE,
  input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
  output logic [1:0]              RSP_VALID,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic                    RSP_ERR,
  output logic                    BUSY,
  input  logic                    HREADY,
  input  logic                    HRESP,
  input  logic [DATA_WIDTH-1:0]   HRDATA,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [ADDR_WIDTH-1:0]   HADDR,
  output logic [DATA_WIDTH-1:0]   HWDATA
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    ownerValid_q, ownerValid_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [7:0]              waitCnt_q, waitCnt_d;

  logic                    anyValid;
  logic                    pickIdx;
  logic [ADDR_WIDTH-1:0]   selAddr;
  logic [DATA_WIDTH-1:0]   selWdata;
  logic                    selWrite;
  logic [7:0]              waitCntInc;
  logic                    timeoutHit;

  // Arbitration. owner_q remembers the last granted requester; when both
  // ask, the other one wins. ownerValid_q is clear until the first grant
  // after reset so that requester 0 wins the very first contention.
  always_comb begin
    anyValid = |REQ_VALID;
    if (REQ_VALID == 2'b11) begin
      pickIdx = ownerValid_q ? ~owner_q : 1'b0;
    end else begin
      pickIdx = REQ_VALID[1];
    end
    selAddr  = pickIdx ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : REQ_ADDR[ADDR_WIDTH-1:0];
    selWdata = pickIdx ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_WDATA[DATA_WIDTH-1:0];
    selWrite = pickIdx ? REQ_WRITE[1] : REQ_WRITE[0];
  end

  // The timeout fires on the wait cycle that would bring the count of
  // consecutive HREADY=0 cycles up to TIMEOUT.
  assign waitCntInc = waitCnt_q + 8'd1;
  assign timeoutHit = (waitCntInc == TimeoutCnt);

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ownerValid_d = ownerValid_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    waitCnt_d    = waitCnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (anyValid) begin
          owner_d      = pickIdx;
          ownerValid_d = 1'b1;
          write_d      = selWrite;
          addr_d       = selAddr;
          wdata_d      = selWdata;
          rdata_d      = '0;
          waitCnt_d    = '0;
          // Misaligned words never reach the bus.
          if (selAddr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (HREADY) begin
          waitCnt_d = '0;
          state_d   = ST_DATA;
        end else if (timeoutHit) begin
          err_d     = 1'b1;
          rdata_d   = '0;
          waitCnt_d = '0;
          state_d   = ST_RESP;
        end else begin
          waitCnt_d = waitCntInc;
        end
      end

      ST_DATA: begin
        // The first cycle of a two-cycle ERROR response has HREADY=0 and is
        // simply waited out; HRESP is sampled on the completing cycle.
        if (HREADY) begin
          err_d     = HRESP;
          rdata_d   = (!write_q && !HRESP) ? HRDATA : '0;
          waitCnt_d = '0;
          state_d   = ST_RESP;
        end else if (timeoutHit) begin
          err_d     = 1'b1;
          rdata_d   = '0;
          waitCnt_d = '0;
          state_d   = ST_RESP;
        end else begin
          waitCnt_d = waitCntInc;
        end
      end

      ST_RESP: begin
        waitCnt_d = '0;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      ownerValid_q <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      waitCnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ownerValid_q <= ownerValid_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      waitCnt_q    <= waitCnt_d;
    end
  end

  // Outputs derived from the current state and the latched command.
  always_comb begin
    REQ_READY = 2'b00;
    RSP_VALID = 2'b00;
    if (state_q == ST_IDLE && anyValid) begin
      REQ_READY = {pickIdx, ~pickIdx};
    end
    if (state_q == ST_RESP) begin
      RSP_VALID = {owner_q, ~owner_q};
    end
  end

  assign HTRANS    = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
  assign HWRITE    = write_q;
  assign HSIZE     = 3'b010;
  assign HADDR     = addr_q;
  assign HWDATA    = wdata_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule
